// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace-tree multiplier.
// The row-count helpers size the reduction layers at elaboration time.
package wallace_pkg;

    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 32;
    localparam int PIPE_SHORT = 2;
    localparam int PIPE_LONG  = 3;
    localparam int CORR_W     = 2 * (WIDTH_MAX + 1);

    // Modified Baugh-Wooley correction for an m-bit signed array: ones at columns m and 2m-1.
    function automatic logic [CORR_W-1:0] bw_correction(input int m);
        logic [CORR_W-1:0] k;
        k = '0;
        k[m] = 1'b1;
        k[2*m-1] = 1'b1;
        return k;
    endfunction

    function automatic int csa_rows_out(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int rows_after(input int n, input int layers);
        int r;
        r = n;
        for (int i = 0; i < layers; i++) r = csa_rows_out(r);
        return r;
    endfunction

    function automatic int csa_layers(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = csa_rows_out(r);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Carry-save adder over LANES independent W-bit lanes: three rows in, sum and carry rows out.
// The carry row is already shifted up one column inside each lane; the lane's top carry wraps off.
module csa_3to2 #(
    parameter int W     = 16,
    parameter int LANES = 1
) (
    input  logic [LANES*W-1:0] x_i,
    input  logic [LANES*W-1:0] y_i,
    input  logic [LANES*W-1:0] z_i,
    output logic [LANES*W-1:0] sum_o,
    output logic [LANES*W-1:0] carry_o
);

    assign sum_o = x_i ^ y_i ^ z_i;

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        assign carry_o[gl*W] = 1'b0;
        assign carry_o[gl*W+1 +: W-1] = (x_i[gl*W +: W-1] & y_i[gl*W +: W-1])
                                      | (x_i[gl*W +: W-1] & z_i[gl*W +: W-1])
                                      | (y_i[gl*W +: W-1] & z_i[gl*W +: W-1]);
    end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined signed/unsigned multiplier: Baugh-Wooley partial products, Wallace 3:2 reduction,
// final carry-propagate add; valid-bit shift chain with a global stall on output backpressure.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PIPE  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    // Operands are extended by one bit (sign or zero) so one signed M-bit array covers both modes.
    localparam int M  = WIDTH + 1;
    localparam int P  = 2 * WIDTH;
    localparam int R  = M + 1;
    localparam int NL = csa_layers(R);
    localparam logic [CORR_W-1:0] CORR_FULL = bw_correction(M);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (PIPE != PIPE_SHORT && PIPE != PIPE_LONG)) begin : g_bad_cfg
        $error("wallace_mult_pipe: unsupported WIDTH/PIPE");
    end

    logic [PIPE-1:0]  vld_q, vld_d;
    logic             stall;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [P-1:0]     prod_q;
    logic [P-1:0]     pp_rows [R];
    logic [P-1:0]     red_s, red_c;
    logic [M-1:0]     ax, bx;

    assign stall       = vld_q[PIPE-1] & ~out_ready;
    assign in_ready    = ~stall | ~vld_q[0];
    assign out_valid   = vld_q[PIPE-1];
    assign out_product = prod_q;
    assign busy        = |vld_q;

    always_comb begin
        vld_d = vld_q;
        if (in_ready) vld_d[0] = in_valid;
        if (!stall) begin
            for (int k = 1; k < PIPE; k++) vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sgn_q <= in_signed;
        end
    end

    assign ax = {sgn_q & a_q[WIDTH-1], a_q};
    assign bx = {sgn_q & b_q[WIDTH-1], b_q};

    // Terms pairing exactly one sign bit are complemented; columns at or above P wrap away.
    always_comb begin
        for (int i = 0; i < R; i++) pp_rows[i] = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                if (i + j < P) pp_rows[i][i+j] = (ax[j] & bx[i]) ^ ((i == M-1) ^ (j == M-1));
            end
        end
        pp_rows[R-1] = CORR_FULL[P-1:0];
    end

    for (genvar gl = 0; gl < NL; gl++) begin : g_layer
        localparam int N_IN  = rows_after(R, gl);
        localparam int G     = N_IN / 3;
        localparam int N_OUT = csa_rows_out(N_IN);

        logic [P-1:0]   rin  [N_IN];
        logic [P-1:0]   rout [N_OUT];
        logic [G*P-1:0] x, y, z, s, c;

        if (gl == 0) begin : g_first
            assign rin = pp_rows;
        end else begin : g_next
            assign rin = g_layer[gl-1].rout;
        end

        for (genvar gk = 0; gk < G; gk++) begin : g_grp
            assign x[gk*P +: P] = rin[3*gk];
            assign y[gk*P +: P] = rin[3*gk+1];
            assign z[gk*P +: P] = rin[3*gk+2];
            assign rout[2*gk]   = s[gk*P +: P];
            assign rout[2*gk+1] = c[gk*P +: P];
        end

        for (genvar gp = 0; gp < N_IN - 3*G; gp++) begin : g_pass
            assign rout[2*G+gp] = rin[3*G+gp];
        end

        csa_3to2 #(.W(P), .LANES(G)) u_csa (
            .x_i     (x),
            .y_i     (y),
            .z_i     (z),
            .sum_o   (s),
            .carry_o (c)
        );
    end

    assign red_s = g_layer[NL-1].rout[0];
    assign red_c = g_layer[NL-1].rout[1];

    if (PIPE == PIPE_LONG) begin : g_p3
        logic [P-1:0] sum_q, cry_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                cry_q <= '0;
            end else if (!stall && vld_q[0]) begin
                sum_q <= red_s;
                cry_q <= red_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                  prod_q <= '0;
            else if (!stall && vld_q[1]) prod_q <= sum_q + cry_q;
        end
    end else begin : g_p2
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                  prod_q <= '0;
            else if (!stall && vld_q[0]) prod_q <= red_s + red_c;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench: an 8-bit/3-stage and a 16-bit/2-stage multiplier checked against integer arithmetic.
module tb_wallace_mult_pipe;

    localparam int LAT8  = 3;
    localparam int LAT16 = 2;

    typedef struct {
        logic [63:0] exp;
        int          cyc;
        bit          lat;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        iv16, ir16, s16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    item_t q8[$];
    item_t q16[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    n_out = 0;
    bit    done16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wallace_mult_pipe #(.WIDTH(8), .PIPE(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_product(p8), .busy(busy8)
    );

    wallace_mult_pipe #(.WIDTH(16), .PIPE(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_signed(s16), .out_valid(ov16), .out_ready(or16), .out_product(p16), .busy(busy16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
    function automatic logic [63:0] ref_mul(input longint a, input longint b, input bit s, input int w);
        longint va, vb, half, full, prod;
        va   = a;
        vb   = b;
        half = longint'(1) << (w - 1);
        full = longint'(1) << w;
        if (s && va >= half) va = va - full;
        if (s && vb >= half) vb = vb - full;
        prod = va * vb;
        return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit lat);
        int n = 0;
        iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
        forever begin
            @(negedge clk);
            if (ir8) break;
            n++;
            if (n > 50) break;
        end
        if (ir8) q8.push_back('{ref_mul(a, b, s, 8), cyc, lat});
        else begin
            total++; bad++;
            $display("FAIL send8_timeout: in_ready stuck at %0b want 1", ir8);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s, input bit lat);
        int n = 0;
        iv16 = 1'b1; a16 = a; b16 = b; s16 = s;
        forever begin
            @(negedge clk);
            if (ir16) break;
            n++;
            if (n > 50) break;
        end
        if (ir16) q16.push_back('{ref_mul(a, b, s, 16), cyc, lat});
        else begin
            total++; bad++;
            $display("FAIL send16_timeout: in_ready stuck at %0b want 1", ir16);
        end
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 64'(q8.size() + q16.size()), 64'd0);
        #1;
    endtask

    logic        hold8 = 1'b0, hold16 = 1'b0;
    logic [15:0] held8;
    logic [31:0] held16;

    always @(negedge clk) begin : mon8
        item_t it;
        if (rst_n) begin
            if (hold8) begin
                check("hold8_valid", 64'(ov8), 64'd1);
                check("hold8_product", 64'(p8), 64'(held8));
            end
            if (ov8 && or8) begin
                n_out++;
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected8: product %0h with empty scoreboard", p8);
                end else begin
                    it = q8.pop_front();
                    check("product8", 64'(p8), it.exp);
                    if (it.lat) check("latency8", 64'(cyc - it.cyc), 64'(LAT8));
                end
            end
            hold8 = ov8 && !or8;
            held8 = p8;
        end else hold8 = 1'b0;
    end

    always @(negedge clk) begin : mon16
        item_t it;
        if (rst_n) begin
            if (hold16) begin
                check("hold16_valid", 64'(ov16), 64'd1);
                check("hold16_product", 64'(p16), 64'(held16));
            end
            if (ov16 && or16) begin
                n_out++;
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected16: product %0h with empty scoreboard", p16);
                end else begin
                    it = q16.pop_front();
                    check("product16", 64'(p16), it.exp);
                    if (it.lat) check("latency16", 64'(cyc - it.cyc), 64'(LAT16));
                end
            end
            hold16 = ov16 && !or16;
            held16 = p16;
        end else hold16 = 1'b0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        logic [15:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'hFFFF; corner[3] = 16'h8000;

        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 1;
        iv16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid8", 64'(ov8), 0);
        check("rst_busy8", 64'(busy8), 0);
        check("rst_in_ready8", 64'(ir8), 1);
        check("rst_product8", 64'(p8), 0);
        check("rst_out_valid16", 64'(ov16), 0);
        check("rst_busy16", 64'(busy16), 0);
        check("rst_in_ready16", 64'(ir16), 1);
        check("rst_product16", 64'(p16), 0);

        rst_n = 1'b1;
        send8(8'd5, 8'd7, 1'b0, 1'b1);
        send8(8'd255, 8'd255, 1'b0, 1'b1);
        send8(8'd29, 8'd255, 1'b0, 1'b1);
        send8(8'hFF, 8'hFF, 1'b1, 1'b1);
        send8(8'h80, 8'h7F, 1'b1, 1'b1);
        send8(8'h80, 8'h80, 1'b1, 1'b1);
        wait_drain();

        fork
            for (int i = 0; i < 16; i++) send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            for (int i = 0; i < 16; i++) send16(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        join
        wait_drain();

        fork
            for (int i = 0; i < 8; i++) send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            begin
                or8 = 1'b0;
                repeat (5) @(negedge clk);
                check("bp_in_ready8", 64'(ir8), 0);
                check("bp_out_valid8", 64'(ov8), 1);
                @(posedge clk); #1;
                or8 = 1'b1;
            end
        join
        wait_drain();

        done16 = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        for (int s = 0; s < 2; s++) send16(corner[i], corner[j], 1'(s), 1'b0);
                done16 = 1'b1;
            end
            begin
                while (!done16) begin
                    @(posedge clk); #1;
                    or16 = 1'($urandom_range(0, 1));
                end
                or16 = 1'b1;
            end
        join
        wait_drain();

        fork
            begin
                send8(8'($urandom), 8'($urandom), 1'b0, 1'b0);
                send8(8'($urandom), 8'($urandom), 1'b1, 1'b0);
            end
            begin
                send16(corner[2], corner[3], 1'b1, 1'b0);
                send16(corner[3], corner[3], 1'b1, 1'b0);
            end
        join
        check("inflight_busy8", 64'(busy8), 1);
        check("inflight_out_valid16", 64'(ov16), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid8", 64'(ov8), 0);
        check("midrst_out_valid16", 64'(ov16), 0);
        check("midrst_busy8", 64'(busy8), 0);
        check("midrst_busy16", 64'(busy16), 0);
        check("midrst_product16", 64'(p16), 0);
        q8.delete();
        q16.delete();
        saved = n_out;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_outputs", 64'(n_out), 64'(saved));
        check("post_rst_busy8", 64'(busy8), 0);
        check("post_rst_busy16", 64'(busy16), 0);

        send8(8'h80, 8'h01, 1'b1, 1'b1);
        send16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
